// File: rtl/i2c_slave.sv
// I2C target with 7-bit address match; byte-wide write sink and read source.
// Latency: data_rx loads on the 8th SCL rise, valid_rx follows one clk later; SDA changes SDA_HOLD clks after each SCL fall.
// Backpressure: none; data_tx must be valid in the tx_req cycle, and the master is never clock-stretched.
module i2c_slave #(
    parameter logic [6:0]  SLAVE_ADDR = 7'b0010000,
    parameter int unsigned SDA_HOLD   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl,
    input  logic       sda_in,
    output logic       sda_oe,
    input  logic [7:0] data_tx,
    output logic       tx_req,
    output logic [7:0] data_rx,
    output logic       valid_rx,
    output logic       busy,
    output logic       addr_hit
);
    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP
    } state_t;

    // A zero hold would drive SDA before data_tx is latched, so the minimum is one clk.
    localparam int unsigned HOLD_EFF = (SDA_HOLD == 0) ? 1 : SDA_HOLD;
    localparam int          HW       = $clog2(HOLD_EFF + 1);

    logic scl_m, scl_s, scl_d;
    logic sda_m, sda_s, sda_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            {scl_m, scl_s, scl_d} <= 3'b111;
            {sda_m, sda_s, sda_d} <= 3'b111;
        end else begin
            scl_m <= scl;
            scl_s <= scl_m;
            scl_d <= scl_s;
            sda_m <= sda_in;
            sda_s <= sda_m;
            sda_d <= sda_s;
        end
    end

    logic scl_rise, scl_fall, start_det, stop_det;
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign start_det = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

    state_t         state;
    logic [3:0]     bit_cnt;
    logic [7:0]     shreg;
    logic           rw;
    logic           nack;
    logic           rx_pend;
    logic [HW-1:0]  hold_cnt;
    logic           pend_val;
    logic           oe_val;

    // In the tx_req cycle the first read bit comes straight from data_tx.
    assign oe_val = tx_req ? ~data_tx[7] : pend_val;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            bit_cnt  <= 4'd0;
            shreg    <= 8'h00;
            rw       <= 1'b0;
            nack     <= 1'b0;
            rx_pend  <= 1'b0;
            hold_cnt <= '0;
            pend_val <= 1'b0;
            sda_oe   <= 1'b0;
            tx_req   <= 1'b0;
            data_rx  <= 8'h00;
            valid_rx <= 1'b0;
            busy     <= 1'b0;
            addr_hit <= 1'b0;
        end else begin
            tx_req   <= 1'b0;
            valid_rx <= rx_pend;
            rx_pend  <= 1'b0;

            if (hold_cnt != '0) begin
                hold_cnt <= hold_cnt - 1'b1;
                if (hold_cnt == HW'(1))
                    sda_oe <= oe_val;
            end

            if (tx_req) begin
                shreg    <= data_tx;
                pend_val <= ~data_tx[7];
            end

            if (stop_det) begin
                state    <= IDLE;
                busy     <= 1'b0;
                addr_hit <= 1'b0;
                sda_oe   <= 1'b0;
                hold_cnt <= '0;
                bit_cnt  <= 4'd0;
            end else if (start_det) begin
                state    <= ADDR;
                busy     <= 1'b1;
                addr_hit <= 1'b0;
                sda_oe   <= 1'b0;
                hold_cnt <= '0;
                bit_cnt  <= 4'd0;
            end else begin
                case (state)
                    IDLE: ;
                    ADDR: begin
                        if (scl_rise) begin
                            shreg   <= {shreg[6:0], sda_s};
                            bit_cnt <= (bit_cnt == 4'd8) ? bit_cnt : bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            bit_cnt <= 4'd0;
                            if (shreg[7:1] == SLAVE_ADDR) begin
                                rw       <= shreg[0];
                                addr_hit <= 1'b1;
                                state    <= ADDR_ACK;
                                hold_cnt <= HW'(HOLD_EFF);
                                pend_val <= 1'b1;
                            end else begin
                                state    <= WAIT_STOP;
                                sda_oe   <= 1'b0;
                                hold_cnt <= '0;
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if (scl_fall) begin
                            bit_cnt  <= 4'd0;
                            hold_cnt <= HW'(HOLD_EFF);
                            pend_val <= 1'b0;
                            tx_req   <= rw;
                            state    <= rw ? RD_DATA : WR_DATA;
                        end
                    end
                    WR_DATA: begin
                        if (scl_rise) begin
                            shreg   <= {shreg[6:0], sda_s};
                            bit_cnt <= (bit_cnt == 4'd8) ? bit_cnt : bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                data_rx <= {shreg[6:0], sda_s};
                                rx_pend <= 1'b1;
                            end
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            bit_cnt  <= 4'd0;
                            hold_cnt <= HW'(HOLD_EFF);
                            pend_val <= 1'b1;
                            state    <= WR_ACK;
                        end
                    end
                    WR_ACK: begin
                        if (scl_fall) begin
                            bit_cnt  <= 4'd0;
                            hold_cnt <= HW'(HOLD_EFF);
                            pend_val <= 1'b0;
                            state    <= WR_DATA;
                        end
                    end
                    RD_DATA: begin
                        // Bit 7 went out on entry; each fall here presents the next bit.
                        if (scl_fall) begin
                            hold_cnt <= HW'(HOLD_EFF);
                            if (bit_cnt == 4'd7) begin
                                bit_cnt  <= 4'd0;
                                pend_val <= 1'b0;
                                state    <= RD_ACK;
                            end else begin
                                pend_val <= ~shreg[6];
                                shreg    <= {shreg[6:0], 1'b0};
                                bit_cnt  <= bit_cnt + 4'd1;
                            end
                        end
                    end
                    RD_ACK: begin
                        if (scl_rise) begin
                            nack    <= sda_s;
                            bit_cnt <= (bit_cnt == 4'd8) ? bit_cnt : bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt != 4'd0) begin
                            bit_cnt <= 4'd0;
                            if (!nack) begin
                                tx_req   <= 1'b1;
                                hold_cnt <= HW'(HOLD_EFF);
                                pend_val <= 1'b0;
                                state    <= RD_DATA;
                            end else begin
                                sda_oe   <= 1'b0;
                                hold_cnt <= '0;
                                state    <= WAIT_STOP;
                            end
                        end
                    end
                    WAIT_STOP: begin
                        sda_oe   <= 1'b0;
                        hold_cnt <= '0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_i2c_slave.sv
// Bus-master stimulus for i2c_slave with transaction-level reference model and scoreboard.
`timescale 1ns/1ps
module tb_i2c_slave;
    localparam logic [6:0] SLV  = 7'h10;
    localparam int         HOLD = 2;
    localparam int         Q    = 8;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       scl     = 1'b1;
    logic       sda_m   = 1'b1;
    logic [7:0] data_tx = 8'h00;
    logic       sda_bus;
    logic       sda_oe, tx_req, valid_rx, busy, addr_hit;
    logic [7:0] data_rx;

    int         checks = 0;
    int         errors = 0;
    int         tx_seen = 0;
    int         tx_exp = 0;
    int         since_fall = 0;
    logic       oe_prev = 1'b0;
    logic [7:0] exp_rx[$];
    logic [7:0] exp_tx[$];
    logic [7:0] pay[$];

    assign sda_bus = sda_m & ~sda_oe;

    i2c_slave #(.SLAVE_ADDR(SLV), .SDA_HOLD(HOLD)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .scl      (scl),
        .sda_in   (sda_bus),
        .sda_oe   (sda_oe),
        .data_tx  (data_tx),
        .tx_req   (tx_req),
        .data_rx  (data_rx),
        .valid_rx (valid_rx),
        .busy     (busy),
        .addr_hit (addr_hit)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, want);
        end
    endtask

    task automatic wq(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic m_start();
        sda_m = 1'b1; wq(Q);
        scl   = 1'b1; wq(Q);
        sda_m = 1'b0; wq(Q);
        scl   = 1'b0; wq(Q);
    endtask

    task automatic m_stop();
        sda_m = 1'b0; wq(Q);
        scl   = 1'b1; wq(Q);
        sda_m = 1'b1; wq(Q);
    endtask

    task automatic m_bit(input logic b, output logic r);
        sda_m = b;    wq(Q);
        scl   = 1'b1; wq(Q);
        r = sda_bus;  wq(Q);
        scl   = 1'b0; wq(Q);
    endtask

    task automatic m_write_byte(input logic [7:0] b, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) m_bit(b[i], r);
        m_bit(1'b1, ack);
    endtask

    task automatic m_read_byte(input logic nack, output logic [7:0] b);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            m_bit(1'b1, r);
            b[i] = r;
        end
        m_bit(nack, r);
    endtask

    // Reference: a target at SLV ACKs its address and every written byte, returns
    // supplied bytes on reads; any other address sees an idle (all-ones) bus.
    task automatic xfer(input logic [6:0] addr, input logic rw, input bit do_stop);
        logic       ack;
        logic [7:0] got;
        bit         hit;
        hit = (addr == SLV);
        m_start();
        check("busy_after_start", int'(busy), 1);
        check("addr_hit_after_start", int'(addr_hit), 0);
        if (hit && rw)
            foreach (pay[i]) begin
                exp_tx.push_back(pay[i]);
                tx_exp++;
            end
        m_write_byte({addr, rw}, ack);
        check("addr_ack", int'(ack), hit ? 0 : 1);
        check("addr_hit", int'(addr_hit), int'(hit));
        foreach (pay[i]) begin
            if (rw) begin
                m_read_byte(i == pay.size() - 1, got);
                check("rd_byte", int'(got), hit ? int'(pay[i]) : 255);
            end else begin
                if (hit) exp_rx.push_back(pay[i]);
                m_write_byte(pay[i], ack);
                check("wr_ack", int'(ack), hit ? 0 : 1);
            end
        end
        check("busy_before_stop", int'(busy), 1);
        if (do_stop) begin
            m_stop();
            check("busy_after_stop", int'(busy), 0);
            check("addr_hit_after_stop", int'(addr_hit), 0);
        end
    endtask

    // Monitor: SDA timing, tx_req responder, data_rx scoreboard.
    always begin
        @(posedge clk);
        #1;
        if (scl) since_fall = 0;
        else since_fall++;
        if (rst_n && sda_oe !== oe_prev)
            check("oe_change_window", int'(since_fall >= HOLD + 2 && since_fall <= HOLD + 4), 1);
        oe_prev = sda_oe;
        if (tx_req) begin
            tx_seen++;
            check("tx_req_expected", int'(exp_tx.size() > 0), 1);
            if (exp_tx.size() > 0) data_tx = exp_tx.pop_front();
        end
        if (valid_rx) begin
            check("valid_rx_expected", int'(exp_rx.size() > 0), 1);
            if (exp_rx.size() > 0) check("data_rx", int'(data_rx), int'(exp_rx.pop_front()));
        end
    end

    initial begin
        #(1_000_000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic       ack;
        logic       r;
        logic [7:0] got;

        wq(4);
        check("rst_sda_oe", int'(sda_oe), 0);
        check("rst_tx_req", int'(tx_req), 0);
        check("rst_valid_rx", int'(valid_rx), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_addr_hit", int'(addr_hit), 0);
        check("rst_data_rx", int'(data_rx), 0);
        rst_n = 1'b1;
        wq(4);

        pay = '{8'hA5};
        xfer(SLV, 1'b0, 1'b1);
        check("data_rx_hold", int'(data_rx), 8'hA5);

        pay = '{8'h5A, 8'hC3};
        xfer(SLV, 1'b1, 1'b1);

        pay = '{8'h3C, 8'h81};
        xfer(7'h59, 1'b0, 1'b1);
        pay = '{8'h77};
        xfer(7'h59, 1'b1, 1'b1);

        // Repeated START four bits into a written byte, then a read.
        m_start();
        m_write_byte({SLV, 1'b0}, ack);
        check("rs_addr_ack", int'(ack), 0);
        check("rs_addr_hit", int'(addr_hit), 1);
        for (int i = 0; i < 4; i++) m_bit(1'($urandom), r);
        pay = '{8'($urandom)};
        xfer(SLV, 1'b1, 1'b1);

        // Reset pulse while the target drives a zero read bit.
        m_start();
        exp_tx.push_back(8'h00);
        tx_exp++;
        m_write_byte({SLV, 1'b1}, ack);
        check("rr_addr_ack", int'(ack), 0);
        m_bit(1'b1, r);
        m_bit(1'b1, r);
        sda_m = 1'b1; wq(Q);
        scl   = 1'b1; wq(Q / 2);
        check("rr_oe_driving", int'(sda_oe), 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rr_oe_released", int'(sda_oe), 0);
        check("rr_busy", int'(busy), 0);
        wq(Q / 2);
        scl = 1'b0; wq(Q);
        got = 8'h00;
        for (int i = 4; i >= 0; i--) begin
            m_bit(1'b1, r);
            got[i] = r;
        end
        check("rr_ignored_bits", int'(got[4:0]), 5'h1F);
        m_bit(1'b0, r);
        m_stop();
        check("rr_busy_idle", int'(busy), 0);
        pay = '{8'($urandom)};
        xfer(SLV, 1'b0, 1'b1);

        for (int t = 0; t < 8; t++) begin
            logic [6:0] a;
            a = ($urandom_range(0, 1) == 0) ? SLV : 7'($urandom);
            pay.delete();
            repeat ($urandom_range(1, 3)) pay.push_back(8'($urandom));
            xfer(a, 1'($urandom), 1'b1);
        end

        wq(20);
        check("rx_queue_drained", exp_rx.size(), 0);
        check("tx_queue_drained", exp_tx.size(), 0);
        check("tx_req_count", tx_seen, tx_exp);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
